// File: rtl/mips_mem_pkg.sv
// Shared memory-side parameters and the store-buffer entry layout.
// Imported by the store buffer and its forwarding search.
package mips_mem_pkg;

   localparam int SB_DEPTH = 4;
   localparam int DM_AW    = 10;
   localparam int DW       = 32;
   localparam int PC_W     = 32;

   typedef struct packed {
      logic [DM_AW-1:0] addr;
      logic [DW-1:0]    data;
      logic [PC_W-1:0]  pc;
   } sb_entry_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Youngest-match search over the queued stores, scanning from tail-1 back to head.
// The first valid address match in that order wins.
module sb_fwd_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 10,
   parameter int DW    = 32
) (
   input  logic [AW-1:0]              addr [DEPTH],
   input  logic [DW-1:0]              data [DEPTH],
   input  logic [$clog2(DEPTH)-1:0]   tail,
   input  logic [$clog2(DEPTH):0]     count,
   input  logic [AW-1:0]              ld_addr,
   output logic                       hit,
   output logic [DW-1:0]              data_out
);
   import mips_mem_pkg::*;

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] idx_s;

   // priority search: youngest valid entry with a matching address
   always_comb begin
      hit      = 1'b0;
      data_out = {DW{1'b0}};
      idx_s    = {PW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         idx_s = tail - PW'(1'b1) - PW'(i);
         if (!hit && (CW'(i) < count) && (addr[idx_s] == ld_addr)) begin
            hit      = 1'b1;
            data_out = data[idx_s];
         end else begin
            hit      = hit;
            data_out = data_out;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Store queue between the MEM stage and the single-port data memory.
// Stores retire one per cycle when no load owns the port; loads forward from the youngest queued store.
module store_buffer #(
   parameter int DEPTH = mips_mem_pkg::SB_DEPTH,
   parameter int AW    = mips_mem_pkg::DM_AW,
   parameter int DW    = mips_mem_pkg::DW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            st_valid,
   input  logic [AW-1:0]   st_addr,
   input  logic [DW-1:0]   st_data,
   input  logic [31:0]     st_pc,
   input  logic            ld_valid,
   input  logic [AW-1:0]   ld_addr,
   output logic [DW-1:0]   ld_data,
   output logic            stall,
   output logic            empty,
   output logic [AW-1:0]   dm_a,
   output logic [DW-1:0]   dm_wd,
   output logic            dm_we,
   output logic [31:0]     dm_pc,
   input  logic [DW-1:0]   dm_rd
);
   import mips_mem_pkg::*;

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]  addr_r [DEPTH];
   logic [DW-1:0]  data_r [DEPTH];
   logic [31:0]    pc_r   [DEPTH];
   logic [PW-1:0]  head_r;
   logic [PW-1:0]  tail_r;
   logic [CW-1:0]  count_r;

   logic           full_s;
   logic           empty_s;
   logic           enq_s;
   logic           deq_s;
   logic           hit_s;
   logic [DW-1:0]  fwd_data_s;

   // occupancy and handshake decode; no drain in the reset cycle so pending stores never reach memory
   always_comb begin
      full_s  = (count_r == CW'(DEPTH));
      empty_s = (count_r == {CW{1'b0}});
      enq_s   = st_valid && !full_s;
      deq_s   = !empty_s && !ld_valid && !reset;
   end

   // head/tail pointers and entry count
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (enq_s) begin
            tail_r <= tail_r + PW'(1'b1);
         end
         if (deq_s) begin
            head_r <= head_r + PW'(1'b1);
         end
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // entry storage, written at the tail on enqueue
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_r[i] <= {AW{1'b0}};
            data_r[i] <= {DW{1'b0}};
            pc_r[i]   <= 32'h0000_0000;
         end
      end else if (enq_s) begin
         addr_r[tail_r] <= st_addr;
         data_r[tail_r] <= st_data;
         pc_r[tail_r]   <= st_pc;
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd (
      .addr     (addr_r),
      .data     (data_r),
      .tail     (tail_r),
      .count    (count_r),
      .ld_addr  (ld_addr),
      .hit      (hit_s),
      .data_out (fwd_data_s)
   );

   // memory port mux: a load owns the address, otherwise the head entry retires
   always_comb begin
      stall = st_valid && full_s;
      empty = empty_s;
      dm_we = deq_s;
      if (ld_valid) begin
         dm_a = ld_addr;
      end else if (empty_s) begin
         dm_a = {AW{1'b0}};
      end else begin
         dm_a = addr_r[head_r];
      end
      if (empty_s) begin
         dm_wd = {DW{1'b0}};
         dm_pc = 32'h0000_0000;
      end else begin
         dm_wd = data_r[head_r];
         dm_pc = pc_r[head_r];
      end
      if (hit_s) begin
         ld_data = fwd_data_s;
      end else begin
         ld_data = dm_rd;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
// The bench also owns the data memory the buffer drains into.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 10;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic [31:0]   st_pc;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          stall;
   logic          empty;
   logic [AW-1:0] dm_a;
   logic [DW-1:0] dm_wd;
   logic          dm_we;
   logic [31:0]   dm_pc;
   logic [DW-1:0] dm_rd;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [31:0]   pc;
   } ent_t;

   ent_t          q[$];
   logic [DW-1:0] mem     [1024];
   logic [DW-1:0] ref_mem [1024];
   int            n_checks = 0;
   int            n_errors = 0;
   logic [31:0]   pc_ctr   = 32'h0000_1000;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk      (clk),
      .reset    (reset),
      .st_valid (st_valid),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_pc    (st_pc),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .stall    (stall),
      .empty    (empty),
      .dm_a     (dm_a),
      .dm_wd    (dm_wd),
      .dm_we    (dm_we),
      .dm_pc    (dm_pc),
      .dm_rd    (dm_rd)
   );

   assign dm_rd = mem[dm_a];

   // data memory: combinational read, write on the rising edge
   always @(posedge clk) begin
      if (dm_we === 1'b1) mem[dm_a] <= dm_wd;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: inputs already driven after the falling edge
   task automatic step();
      bit            full;
      bit            exp_we;
      bit            hit;
      logic [DW-1:0] exp_ld;
      #1;
      if (st_valid && ld_valid) $display("note: protocol violation, store and load issued together");
      full   = (q.size() == DEPTH);
      exp_we = !reset && (q.size() > 0) && !ld_valid;
      check_eq("stall", stall, st_valid && full);
      check_eq("empty", empty, q.size() == 0);
      check_eq("dm_we", dm_we, exp_we);
      if (ld_valid) begin
         hit    = 1'b0;
         exp_ld = ref_mem[ld_addr];
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].a == ld_addr) begin
               hit    = 1'b1;
               exp_ld = q[i].d;
            end
         end
         check_eq("ld_dm_a", dm_a, ld_addr);
         check_eq("ld_data", ld_data, exp_ld);
      end else if (exp_we) begin
         check_eq("dm_a", dm_a, q[0].a);
         check_eq("dm_wd", dm_wd, q[0].d);
         check_eq("dm_pc", dm_pc, q[0].pc);
      end else if (q.size() == 0) begin
         check_eq("idle_dm_a", dm_a, 0);
      end
      @(posedge clk);
      if (reset) begin
         q.delete();
      end else begin
         if (exp_we) begin
            ref_mem[q[0].a] = q[0].d;
            void'(q.pop_front());
         end
         if (st_valid && !full) q.push_back('{a: st_addr, d: st_data, pc: st_pc});
      end
      @(negedge clk);
   endtask

   task automatic set_idle();
      reset    = 1'b0;
      st_valid = 1'b0;
      ld_valid = 1'b0;
      st_addr  = 10'h000;
      st_data  = 32'h0;
      st_pc    = 32'h0;
      ld_addr  = 10'h000;
   endtask

   // issue a store and hold it while the buffer stalls
   task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int g = 0;
      bit held;
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_pc    = pc_ctr;
      do begin
         held = (q.size() == DEPTH);
         step();
         g++;
      end while (held && g < 50);
      if (held) check_eq("store_timeout", 1, 0);
      pc_ctr   = pc_ctr + 32'd4;
      st_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      set_idle();
      while (q.size() > 0 && g < 20) begin
         step();
         g++;
      end
      #1 check_eq("drain_empty", empty, 1);
   endtask

   initial begin
      int sent;
      bit acc;
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      set_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset then idle
      #1;
      check_eq("rst_empty", empty, 1);
      check_eq("rst_dm_we", dm_we, 0);
      check_eq("rst_stall", stall, 0);
      check_eq("rst_dm_a", dm_a, 0);
      step();
      step();

      // single store then idle
      do_store(10'h004, 32'hDEAD_BEEF);
      #1 check_eq("st4_we", dm_we, 1);
      check_eq("st4_a", dm_a, 10'h004);
      step();
      #1 check_eq("st4_mem", mem[4], 32'hDEAD_BEEF);
      check_eq("st4_empty", empty, 1);

      // two stores to the same word, then a load: youngest wins
      do_store(10'h010, 32'h0000_0011);
      do_store(10'h010, 32'h0000_0022);
      ld_valid = 1'b1;
      ld_addr  = 10'h010;
      #1 check_eq("fwd_young", ld_data, 32'h0000_0022);
      step();
      drain();
      check_eq("fwd_mem", mem[16], 32'h0000_0022);

      // load stream blocks draining while 5 stores arrive
      sent = 0;
      for (int c = 0; c < 6; c++) begin
         ld_valid = 1'b1;
         ld_addr  = 10'($urandom_range(256, 260));
         if (sent < 5) begin
            st_valid = 1'b1;
            st_addr  = 10'h100 + 10'(sent);
            st_data  = 32'hA000_0000 + 32'(sent);
            st_pc    = pc_ctr;
            acc      = (q.size() < DEPTH);
         end else begin
            st_valid = 1'b0;
            acc      = 1'b0;
         end
         step();
         if (acc) begin
            sent++;
            pc_ctr = pc_ctr + 32'd4;
         end
      end
      ld_valid = 1'b0;
      st_valid = 1'b1;
      #1 check_eq("full_stall", stall, 1);
      do_store(10'h100 + 10'(sent), 32'hA000_0000 + 32'(sent));
      drain();
      check_eq("stall_last", mem[10'h104], 32'hA000_0004);

      // wrap: store/drain pairs across the pointer wrap
      for (int k = 0; k < 10; k++) begin
         do_store(10'h020 + 10'(k), 32'hC0DE_0000 + 32'(k));
         step();
      end
      drain();

      // load of an unqueued address with the queue non-empty
      do_store(10'h050, 32'h1234_5678);
      ld_valid = 1'b1;
      ld_addr  = 10'h3FF;
      #1 check_eq("miss_ld", ld_data, mem[10'h3FF]);
      check_eq("miss_a", dm_a, 10'h3FF);
      check_eq("miss_we", dm_we, 0);
      step();
      drain();

      // reset discards pending stores
      ld_valid = 1'b1;
      ld_addr  = 10'h3FE;
      for (int k = 0; k < 3; k++) begin
         st_valid = 1'b1;
         st_addr  = 10'h200 + 10'(k);
         st_data  = 32'hBAD0_0000 + 32'(k);
         st_pc    = pc_ctr;
         step();
         pc_ctr = pc_ctr + 32'd4;
      end
      set_idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1 check_eq("rst_q_empty", empty, 1);
      check_eq("rst_q_we", dm_we, 0);
      step();
      step();
      for (int k = 0; k < 3; k++) check_eq("rst_discard", mem[10'h200 + k], ref_mem[10'h200 + k]);

      // random mix of stores, loads and idle cycles
      for (int n = 0; n < 400; n++) begin
         int r;
         set_idle();
         r = $urandom_range(0, 9);
         if (r < 4) begin
            do_store(10'($urandom_range(0, 15)), $urandom);
         end else if (r < 8) begin
            ld_valid = 1'b1;
            ld_addr  = 10'($urandom_range(0, 15));
            step();
         end else begin
            step();
         end
      end
      drain();

      for (int i = 0; i < 1024; i++) begin
         if (mem[i] !== ref_mem[i]) check_eq("final_mem", mem[i], ref_mem[i]);
      end
      check_eq("final_mem_any", mem[16], ref_mem[16]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
